// File: rtl/jam_pkg.sv
// Shared types and constant helpers for the job-assignment search engine.
package jam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    COMP,
    STEP,
    DONE
  } state_t;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  // Ceiling log2; returns 0 for values of 1 or less.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int factorial(input int value);
    int r;
    r = 1;
    for (int k = 2; k <= value; k++) r = r * k;
    return r;
  endfunction

endpackage

// File: rtl/jam_perm_next.sv
// Multi-cycle lexicographic next-permutation engine.
// One cycle to locate the pivot and swap it, then one element pair per cycle
// to reverse the suffix. `last` flags a fully descending input permutation.
module jam_perm_next
  import jam_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = clog2(N)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               go,
  input  logic [N*IDX_W-1:0] p_in,
  output logic [N*IDX_W-1:0] p_out,
  output logic               done,
  output logic               last
);

  typedef enum logic [1:0] {
    PN_IDLE,
    PN_SWAP,
    PN_REV
  } pn_state_t;

  pn_state_t        state_q, state_d;
  logic [IDX_W-1:0] w [N];
  logic [IDX_W-1:0] lo, hi;
  logic [IDX_W-1:0] piv, piv_m1, sw;

  // Pivot is the largest i with w[i-1] < w[i]; sw is the rightmost element beyond it that exceeds w[i-1].
  always_comb begin
    piv = '0;
    for (int k = 1; k < N; k++) begin
      if (w[k-1] < w[k]) piv = IDX_W'(k);
    end
    piv_m1 = piv - 1'b1;
    sw     = piv;
    for (int k = 0; k < N; k++) begin
      if ((IDX_W'(k) >= piv) && (w[k] > w[piv_m1])) sw = IDX_W'(k);
    end
  end

  // A permutation with no ascending neighbour pair is the final one.
  always_comb begin
    last = 1'b1;
    for (int k = 1; k < N; k++) begin
      if (p_in[(k-1)*IDX_W +: IDX_W] < p_in[k*IDX_W +: IDX_W]) last = 1'b0;
    end
  end

  // Present the working array as a packed vector.
  always_comb begin
    p_out = '0;
    for (int k = 0; k < N; k++) p_out[k*IDX_W +: IDX_W] = w[k];
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= PN_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and done strobe.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      PN_IDLE: if (go) state_d = PN_SWAP;
      PN_SWAP: state_d = PN_REV;
      PN_REV: begin
        if (lo >= hi) begin
          done    = 1'b1;
          state_d = PN_IDLE;
        end
      end
      default: state_d = PN_IDLE;
    endcase
  end

  // Working array: load, pivot swap, then suffix reversal.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lo <= '0;
      hi <= '0;
      for (int k = 0; k < N; k++) w[k] <= '0;
    end else begin
      case (state_q)
        PN_IDLE: begin
          if (go) begin
            for (int k = 0; k < N; k++) w[k] <= p_in[k*IDX_W +: IDX_W];
          end
        end
        PN_SWAP: begin
          w[piv_m1] <= w[sw];
          w[sw]     <= w[piv_m1];
          lo        <= piv;
          hi        <= IDX_W'(N - 1);
        end
        PN_REV: begin
          if (lo < hi) begin
            w[lo] <= w[hi];
            w[hi] <= w[lo];
            lo    <= lo + 1'b1;
            hi    <= hi - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/jam_search.sv
// Exhaustive job-assignment search: walks all N! permutations in lexicographic
// order, sums N ROM costs for each and keeps the min (or max) total, its
// multiplicity and the first permutation that reached it.
module jam_search
  import jam_pkg::*;
#(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int IDX_W  = clog2(N),
  parameter int SUM_W  = COST_W + clog2(N),
  parameter int MC_W   = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               mode,
  output logic [IDX_W-1:0]   W,
  output logic [IDX_W-1:0]   J,
  input  logic [COST_W-1:0]  Cost,
  output logic               busy,
  output logic               Valid,
  output logic [SUM_W-1:0]   MinCost,
  output logic [MC_W-1:0]    MatchCount,
  output logic [N*IDX_W-1:0] BestPerm
);

  localparam int CNT_W = clog2(N + 1);

  function automatic logic [N*IDX_W-1:0] identity();
    logic [N*IDX_W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*IDX_W +: IDX_W] = IDX_W'(k);
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   p [N];
  logic [N*IDX_W-1:0] p_packed, p_next;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [SUM_W-1:0]   acc;
  logic               mode_q, first;
  logic               accept, go, pn_done, last, better;

  assign cnt_nxt = cnt + 1'b1;
  assign better  = (mode_q == MODE_MAX) ? (acc > MinCost) : (acc < MinCost);

  // Pack the current permutation for the step engine.
  always_comb begin
    p_packed = '0;
    for (int k = 0; k < N; k++) p_packed[k*IDX_W +: IDX_W] = p[k];
  end

  jam_perm_next #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_perm_next (
    .CLK   (CLK),
    .RST   (RST),
    .go    (go),
    .p_in  (p_packed),
    .p_out (p_next),
    .done  (pn_done),
    .last  (last)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Sequencing: start acceptance, fetch length, final-permutation exit.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    go      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: if (cnt == CNT_W'(N)) state_d = COMP;
      COMP: begin
        if (last) begin
          state_d = DONE;
        end else begin
          go      = 1'b1;
          state_d = STEP;
        end
      end
      STEP: if (pn_done) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: ROM addressing, accumulation (cost lags address by one cycle) and best tracking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      W          <= '0;
      J          <= '0;
      busy       <= 1'b0;
      Valid      <= 1'b0;
      MinCost    <= '0;
      MatchCount <= '0;
      BestPerm   <= identity();
      acc        <= '0;
      cnt        <= '0;
      mode_q     <= MODE_MIN;
      first      <= 1'b0;
      for (int k = 0; k < N; k++) p[k] <= IDX_W'(k);
    end else begin
      busy  <= (state_d == FETCH) || (state_d == COMP) || (state_d == STEP);
      Valid <= (state_d == DONE);
      case (state_q)
        IDLE, DONE: begin
          W <= '0;
          J <= '0;
          if (accept) begin
            acc    <= '0;
            cnt    <= '0;
            mode_q <= mode;
            first  <= 1'b1;
            for (int k = 0; k < N; k++) p[k] <= IDX_W'(k);
          end
        end
        FETCH: begin
          if (cnt != '0) acc <= acc + SUM_W'(Cost);
          cnt <= cnt_nxt;
          if (cnt_nxt < CNT_W'(N)) begin
            W <= cnt_nxt[IDX_W-1:0];
            J <= p[cnt_nxt[IDX_W-1:0]];
          end else begin
            W <= '0;
            J <= '0;
          end
        end
        COMP: begin
          first <= 1'b0;
          if (first || better) begin
            MinCost    <= acc;
            MatchCount <= MC_W'(1);
            BestPerm   <= p_packed;
          end else if (acc == MinCost) begin
            MatchCount <= MatchCount + 1'b1;
          end
        end
        STEP: begin
          if (pn_done) begin
            acc <= '0;
            cnt <= '0;
            W   <= '0;
            J   <= p_next[IDX_W-1:0];
            for (int k = 0; k < N; k++) p[k] <= p_next[k*IDX_W +: IDX_W];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_search.sv
// Self-checking bench: an N=6 instance (full search fits the cycle budget)
// plus an N=3 instance, checked against a rank-decoding reference model.
module tb_jam_search;

  localparam int BOUND6 = 720 * (2 * 6 + 4);
  localparam int BOUND3 = 6 * (2 * 3 + 4);

  logic        CLK = 1'b0;
  logic        RST;
  logic        start6, mode6, start3, mode3;
  logic [2:0]  W6, J6;
  logic [1:0]  W3, J3;
  logic [6:0]  cost6, cost3;
  logic        busy6, valid6, busy3, valid3;
  logic [9:0]  min6;
  logic [8:0]  min3;
  logic [15:0] mc6, mc3;
  logic [17:0] bp6;
  logic [5:0]  bp3;

  int rom6 [6][6];
  int rom3 [3][3];
  int cm   [8][8];
  int exp_best, exp_cnt;
  int exp_perm [8];
  int n_checks = 0;
  int n_err    = 0;

  always #5 CLK = ~CLK;

  jam_search #(.N(6)) dut6 (
    .CLK(CLK), .RST(RST), .start(start6), .mode(mode6), .W(W6), .J(J6), .Cost(cost6),
    .busy(busy6), .Valid(valid6), .MinCost(min6), .MatchCount(mc6), .BestPerm(bp6)
  );

  jam_search #(.N(3)) dut3 (
    .CLK(CLK), .RST(RST), .start(start3), .mode(mode3), .W(W3), .J(J3), .Cost(cost3),
    .busy(busy3), .Valid(valid3), .MinCost(min3), .MatchCount(mc3), .BestPerm(bp3)
  );

  // Cost ROMs with one-cycle read latency.
  always @(posedge CLK) begin
    cost6 <= (W6 < 3'd6 && J6 < 3'd6) ? 7'(rom6[W6][J6]) : 7'd0;
    cost3 <= (W3 < 2'd3 && J3 < 2'd3) ? 7'(rom3[W3][J3]) : 7'd0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int fact(input int n);
    int r;
    r = 1;
    for (int k = 2; k <= n; k++) r = r * k;
    return r;
  endfunction

  function automatic logic [63:0] pack(input int p [8], input int n, input int w);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r = r | (64'(p[k]) << (k * w));
    return r;
  endfunction

  // Reference: the r-th permutation in lexicographic order is decoded from r
  // in the factorial number system, so ranks 0..n!-1 visit them in order.
  task automatic model(input int n, input bit m);
    int avail [8];
    int perm [8];
    int rr, f, idx, s;
    exp_cnt  = 0;
    exp_best = 0;
    for (int r = 0; r < fact(n); r++) begin
      for (int k = 0; k < 8; k++) begin
        avail[k] = k;
        perm[k]  = 0;
      end
      rr = r;
      s  = 0;
      for (int pos = 0; pos < n; pos++) begin
        f   = fact(n - 1 - pos);
        idx = rr / f;
        rr  = rr % f;
        perm[pos] = avail[idx];
        for (int q = idx; q < n - 1 - pos; q++) avail[q] = avail[q+1];
        s = s + cm[pos][perm[pos]];
      end
      if (r == 0 || (m ? (s > exp_best) : (s < exp_best))) begin
        exp_best = s;
        exp_cnt  = 1;
        exp_perm = perm;
      end else if (s == exp_best) begin
        exp_cnt++;
      end
    end
  endtask

  task automatic load6();
    for (int w = 0; w < 6; w++)
      for (int j = 0; j < 6; j++) rom6[w][j] = cm[w][j];
  endtask

  task automatic check_reset6(input string tag);
    int id [8];
    for (int k = 0; k < 8; k++) id[k] = k;
    chk({tag, "_W"},     64'(W6), 64'd0);
    chk({tag, "_J"},     64'(J6), 64'd0);
    chk({tag, "_busy"},  64'(busy6), 64'd0);
    chk({tag, "_valid"}, 64'(valid6), 64'd0);
    chk({tag, "_min"},   64'(min6), 64'd0);
    chk({tag, "_count"}, 64'(mc6), 64'd0);
    chk({tag, "_perm"},  64'(bp6), pack(id, 6, 3));
  endtask

  // Start a search on the N=6 instance and wait for Valid; optionally pulse
  // start (with the opposite mode) while busy at cycle pulse_at.
  task automatic run6(input string tag, input bit m, input int pulse_at);
    int lat;
    @(negedge CLK);
    start6 = 1'b1;
    mode6  = m;
    @(negedge CLK);
    start6 = 1'b0;
    mode6  = ~m;
    chk({tag, "_busy_after_start"},  64'(busy6), 64'd1);
    chk({tag, "_valid_after_start"}, 64'(valid6), 64'd0);
    lat = 0;
    while (!valid6 && lat < BOUND6) begin
      start6 = (lat == pulse_at);
      @(negedge CLK);
      lat++;
    end
    start6 = 1'b0;
    chk({tag, "_valid_in_bound"}, 64'(valid6), 64'd1);
    chk({tag, "_busy_at_valid"},  64'(busy6), 64'd0);
    chk({tag, "_latency_le_bound"}, 64'(lat <= BOUND6), 64'd1);
  endtask

  task automatic check6_model(input string tag, input bit m);
    model(6, m);
    chk({tag, "_min"},   64'(min6), 64'(exp_best));
    chk({tag, "_count"}, 64'(mc6), 64'(exp_cnt));
    chk({tag, "_perm"},  64'(bp6), pack(exp_perm, 6, 3));
  endtask

  initial begin
    int id [8];
    int anti [8];
    int lat3;
    logic [9:0] held_min;

    for (int k = 0; k < 8; k++) begin
      id[k]   = k;
      anti[k] = (k < 6) ? 5 - k : 0;
    end
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) cm[w][j] = 0;
    load6();
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 3; j++) rom3[w][j] = 3 * w + j;

    RST    = 1'b1;
    start6 = 1'b0;
    mode6  = 1'b0;
    start3 = 1'b0;
    mode3  = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset6("reset");
    chk("reset3_valid", 64'(valid3), 64'd0);
    RST = 1'b0;

    // All costs equal: every permutation ties.
    for (int w = 0; w < 6; w++)
      for (int j = 0; j < 6; j++) cm[w][j] = 1;
    load6();
    run6("ones", 1'b0, -1);
    chk("ones_min",   64'(min6), 64'd6);
    chk("ones_count", 64'(mc6), 64'd720);
    chk("ones_perm",  64'(bp6), pack(id, 6, 3));
    held_min = min6;
    repeat (20) @(negedge CLK);
    chk("ones_valid_held", 64'(valid6), 64'd1);
    chk("ones_min_held",   64'(min6), 64'(held_min));

    // Zero diagonal: identity is the unique minimum.
    for (int w = 0; w < 6; w++)
      for (int j = 0; j < 6; j++) cm[w][j] = (w == j) ? 0 : 1;
    load6();
    run6("diag", 1'b0, -1);
    chk("diag_min",   64'(min6), 64'd0);
    chk("diag_count", 64'(mc6), 64'd1);
    chk("diag_perm",  64'(bp6), pack(id, 6, 3));

    // Anti-diagonal of 100 in max mode: the final permutation wins.
    for (int w = 0; w < 6; w++)
      for (int j = 0; j < 6; j++) cm[w][j] = (j == 5 - w) ? 100 : 0;
    load6();
    run6("anti", 1'b1, -1);
    chk("anti_min",   64'(min6), 64'd600);
    chk("anti_count", 64'(mc6), 64'd1);
    chk("anti_perm",  64'(bp6), pack(anti, 6, 3));

    // Random costs (small range to provoke ties); start pulsed while busy is ignored.
    for (int w = 0; w < 6; w++)
      for (int j = 0; j < 6; j++) cm[w][j] = $urandom_range(0, 7);
    load6();
    run6("rnd_min", 1'b0, 100);
    check6_model("rnd_min", 1'b0);

    // Restart from DONE with the other mode on the same costs.
    run6("rnd_max", 1'b1, -1);
    check6_model("rnd_max", 1'b1);

    // Reset 500 cycles into a search, then a clean rerun.
    for (int w = 0; w < 6; w++)
      for (int j = 0; j < 6; j++) cm[w][j] = $urandom_range(0, 127);
    load6();
    @(negedge CLK);
    start6 = 1'b1;
    mode6  = 1'b0;
    @(negedge CLK);
    start6 = 1'b0;
    repeat (500) @(negedge CLK);
    chk("abort_busy_before_rst", 64'(busy6), 64'd1);
    RST = 1'b1;
    @(negedge CLK);
    check_reset6("abort");
    RST = 1'b0;
    run6("after_abort", 1'b1, -1);
    check6_model("after_abort", 1'b1);

    // N=3, cost 3w+j: all six permutations total 12.
    @(negedge CLK);
    start3 = 1'b1;
    mode3  = 1'b0;
    @(negedge CLK);
    start3 = 1'b0;
    lat3   = 0;
    while (!valid3 && lat3 < BOUND3) begin
      @(negedge CLK);
      lat3++;
    end
    chk("n3_valid",   64'(valid3), 64'd1);
    chk("n3_latency", 64'(lat3 <= BOUND3), 64'd1);
    chk("n3_min",     64'(min3), 64'd12);
    chk("n3_count",   64'(mc3), 64'd6);
    chk("n3_perm",    64'(bp3), 64'h24);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
